// File: rtl/regfile_sb.sv
// Register file with a per-register busy (scoreboard) bit and a running count of busy registers.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data and clear busy on the read path.
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRP  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRP-1:0]      rd_en,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_busy,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic [AW:0]     cnt_next;
    logic            wb_hit;
    logic            rsv_hit;
    logic            cnt_inc;
    logic            cnt_dec;

    assign wb_hit  = wb_en && (wb_addr != '0);
    assign rsv_hit = rsv_en && (rsv_addr != '0);

    // Reserve is applied after writeback so it wins on a same-address collision.
    always_comb begin
        busy_next = busy;
        if (wb_hit)
            busy_next[wb_addr] = 1'b0;
        if (rsv_hit)
            busy_next[rsv_addr] = 1'b1;
        if (flush)
            busy_next = '0;
    end

    // At most one bit can rise and one can fall per cycle, so +1/-1 tracking stays exact.
    always_comb begin
        cnt_inc  = rsv_hit && !busy[rsv_addr];
        cnt_dec  = wb_hit && busy[wb_addr] && !(rsv_hit && (rsv_addr == wb_addr));
        cnt_next = busy_cnt + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
        if (flush)
            cnt_next = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                mem[i] <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wb_hit)
                mem[wb_addr] <= wb_data;
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

    for (genvar k = 0; k < NRP; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            bsy;

        assign addr = rd_addr[k*AW +: AW];

        always_comb begin
            data = '0;
            bsy  = 1'b0;
            if (rd_en[k] && (addr != '0)) begin
`ifdef REGFILE_BYPASS_EN
                if (wb_hit && (wb_addr == addr)) begin
                    data = wb_data;
                    bsy  = 1'b0;
                end else begin
                    data = mem[addr];
                    bsy  = busy[addr];
                end
`else
                data = mem[addr];
                bsy  = busy[addr];
`endif
            end
        end

        assign rd_data[k*XLEN +: XLEN] = data;
        assign rd_busy[k]              = bsy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, write/read, scoreboard counting, x0 rules, flush, reset priority.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRP  = 2;
    localparam int AW   = 5;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [NRP-1:0]      rd_en;
    logic [NRP*AW-1:0]   rd_addr;
    logic [NRP*XLEN-1:0] rd_data;
    logic [NRP-1:0]      rd_busy;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic                wb_en;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic                flush;
    logic [AW:0]         busy_cnt;

    int passed = 0;
    int total  = 0;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic ops_clear();
        rst = 1'b0; rsv_en = 1'b0; rsv_addr = '0; wb_en = 1'b0; wb_addr = '0;
        wb_data = '0; flush = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_en   = 2'b11;
        rd_addr = {a1, a0};
    endtask

    // Drive at negedge, let combinational outputs settle before checking.
    task automatic next_cycle();
        @(negedge clk);
        ops_clear();
    endtask

    initial begin
        ops_clear();
        rd_en = '0; rd_addr = '0;

        // Reset, even with pending ops: reset wins.
        @(negedge clk);
        rst = 1'b1; wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234; rsv_en = 1'b1; rsv_addr = 5'd5;
        next_cycle();
        rd(5'd5, 5'd5); #1;
        chk("rst_rd0_data", rd_data[0 +: 32], 0);
        chk("rst_rd1_data", rd_data[32 +: 32], 0);
        chk("rst_busy", rd_busy, 2'b00);
        chk("rst_cnt", busy_cnt, 0);

        // Write x3, read same cycle and next cycle.
        @(negedge clk);
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF; rd(5'd3, 5'd3); #1;
        chk("wb_same_cycle", rd_data[0 +: 32], BYP ? 32'hDEADBEEF : 32'h0);
        next_cycle();
        rd(5'd3, 5'd3); #1;
        chk("wb_next_p0", rd_data[0 +: 32], 32'hDEADBEEF);
        chk("wb_next_p1", rd_data[32 +: 32], 32'hDEADBEEF);

        // rd_en low forces zeros.
        rd_en = 2'b10; #1;
        chk("rden_off_data", rd_data[0 +: 32], 0);

        // Reserve x7 then x9, then writeback x7.
        @(negedge clk);
        rsv_en = 1'b1; rsv_addr = 5'd7;
        next_cycle();
        rd(5'd7, 5'd9); #1;
        chk("rsv7_cnt", busy_cnt, 1);
        chk("rsv7_busy", rd_busy, 2'b01);
        rsv_en = 1'b1; rsv_addr = 5'd9;
        next_cycle();
        rd(5'd7, 5'd9); #1;
        chk("rsv9_cnt", busy_cnt, 2);
        chk("rsv9_busy", rd_busy, 2'b11);
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h77; #1;
        chk("wb7_same_busy", rd_busy[0], BYP ? 1'b0 : 1'b1);
        next_cycle();
        rd(5'd7, 5'd9); #1;
        chk("wb7_busy", rd_busy, 2'b10);
        chk("wb7_cnt", busy_cnt, 1);
        chk("wb7_data", rd_data[0 +: 32], 32'h77);

        // Same-cycle reserve and writeback of x4: reserve wins.
        rsv_en = 1'b1; rsv_addr = 5'd4; wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h11;
        next_cycle();
        rd(5'd4, 5'd4); #1;
        chk("rw4_data", rd_data[32 +: 32], 32'h11);
        chk("rw4_busy", rd_busy, 2'b11);
        chk("rw4_cnt", busy_cnt, 2);

        // x0 ignores write and reserve.
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF; rsv_en = 1'b1; rsv_addr = 5'd0;
        rd(5'd0, 5'd0); #1;
        chk("x0_same_data", rd_data[0 +: 32], 0);
        next_cycle();
        rd(5'd0, 5'd0); #1;
        chk("x0_data", rd_data[0 +: 32], 0);
        chk("x0_busy", rd_busy, 2'b00);
        chk("x0_cnt", busy_cnt, 2);

        // Re-reserve busy x4 (no change) and writeback non-busy x3 (no change).
        rsv_en = 1'b1; rsv_addr = 5'd4; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
        next_cycle();
        rd(5'd3, 5'd4); #1;
        chk("rebusy_cnt", busy_cnt, 2);
        chk("rebusy_busy", rd_busy, 2'b10);
        chk("wb3_data", rd_data[0 +: 32], 32'h33);

        // Reserve x5 and release x9 together: count unchanged.
        rsv_en = 1'b1; rsv_addr = 5'd5; wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
        next_cycle();
        rd(5'd5, 5'd9); #1;
        chk("swap_cnt", busy_cnt, 2);
        chk("swap_busy", rd_busy, 2'b01);
        rsv_en = 1'b1; rsv_addr = 5'd9;
        next_cycle();
        #1;
        chk("three_cnt", busy_cnt, 3);

        // Flush with same-cycle reserve x2 and write x6.
        flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd2; wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h66;
        next_cycle();
        rd(5'd2, 5'd6); #1;
        chk("flush_cnt", busy_cnt, 0);
        chk("flush_busy", rd_busy, 2'b00);
        chk("flush_wb", rd_data[32 +: 32], 32'h66);
        rd(5'd4, 5'd9); #1;
        chk("flush_keep", rd_data[0 +: 32], 32'h11);
        chk("flush_busy2", rd_busy, 2'b00);

        // Mid-sequence reset with busy state and pending ops.
        rsv_en = 1'b1; rsv_addr = 5'd8;
        next_cycle();
        #1;
        chk("pre_rst_cnt", busy_cnt, 1);
        rst = 1'b1; flush = 1'b1; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hABCD; rsv_en = 1'b1; rsv_addr = 5'd10;
        next_cycle();
        rd(5'd3, 5'd8); #1;
        chk("rst2_d0", rd_data[0 +: 32], 0);
        chk("rst2_busy", rd_busy, 2'b00);
        chk("rst2_cnt", busy_cnt, 0);
        rd(5'd6, 5'd4); #1;
        chk("rst2_d1", rd_data, 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
